// File: rtl/eth_fcs_pkg.sv
// Shared constants, types and helpers for the Ethernet FCS inserter.
// Latency: n/a (package). Backpressure: n/a.
// CRC32 is the reflected form of the IEEE 802.3 polynomial.
package eth_fcs_pkg;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic {PASS = 1'b0, EXTRA = 1'b1} state_t;

    typedef struct packed {
        logic [127:0] dat;
        logic [2:0]   ovf;
    } merge_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        return c;
    endfunction

    // Contiguous-from-bit-0 strobe to byte count; anything else is illegal and yields 0.
    function automatic logic [4:0] strb_to_count(input logic [15:0] strb);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 1; i <= 16; i++)
            if (strb == 16'((17'd1 << i) - 17'd1)) n = 5'(i);
        return n;
    endfunction

    // Keeps bytes below n, drops the FCS in LSB-first from byte n, zeros the rest.
    function automatic merge_t fcs_merge(input logic [127:0] dat, input logic [4:0] n,
                                         input logic [31:0] fcs);
        merge_t m;
        m.dat = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n))
                m.dat[8*i +: 8] = dat[8*i +: 8];
            else if (i < int'(n) + 4)
                m.dat[8*i +: 8] = fcs[8*(i-int'(n)) +: 8];
        end
        m.ovf = (n > 5'd12) ? 3'(n - 5'd12) : 3'd0;
        return m;
    endfunction

endpackage

// File: rtl/eth_crc_step.sv
// Advances a reflected CRC32 over the first count bytes (1..16) of a 128-bit beat.
// Latency: combinational. Backpressure: none.
// The chain computes every prefix width and the byte count selects one.
module eth_crc_step
    import eth_fcs_pkg::*;
(
    input  logic [31:0]  crc_in,
    input  logic [127:0] data,
    input  logic [4:0]   count,
    output logic [31:0]  crc_out
);

    always_comb begin
        logic [31:0] c;
        c       = crc_in;
        crc_out = crc_in;
        for (int i = 0; i < 16; i++) begin
            c = crc_byte(c, data[8*i +: 8]);
            if (5'(i + 1) == count) crc_out = c;
        end
    end

endmodule

// File: rtl/axis_eth_fcs_insert.sv
// Appends the Ethernet FCS to a 128-bit AXI4-Stream frame, adding one beat when it does not fit.
// Latency: 1 cycle, output fully registered; EXTRA beat follows the last input beat.
// Backpressure: output held while stalled; input_axis_tready low when output full or in EXTRA.
module axis_eth_fcs_insert
    import eth_fcs_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] input_axis_tdata,
    input  logic [15:0]  input_axis_tstrb,
    input  logic         input_axis_tvalid,
    output logic         input_axis_tready,
    input  logic         input_axis_tlast,
    output logic [127:0] output_axis_tdata,
    output logic [15:0]  output_axis_tstrb,
    output logic         output_axis_tvalid,
    input  logic         output_axis_tready,
    output logic         output_axis_tlast,
    output logic [31:0]  output_fcs,
    output logic         output_fcs_valid,
    output logic         bad_strb
);

    state_t       state_q, state_d;
    logic [31:0]  crc_q, crc_d;
    logic [31:0]  fcs_hold_q, fcs_hold_d;
    logic [2:0]   hold_cnt_q, hold_cnt_d;
    logic [127:0] out_dat_q, out_dat_d;
    logic [15:0]  out_strb_q, out_strb_d;
    logic         out_vld_q, out_vld_d;
    logic         out_last_q, out_last_d;
    logic [31:0]  fcs_q, fcs_d;
    logic         fcs_vld_q, fcs_vld_d;
    logic         bad_strb_q, bad_strb_d;

    logic         out_free, in_rdy, in_fire;
    logic [4:0]   strb_cnt, byte_cnt;
    logic         strb_ok;
    logic [31:0]  crc_fin, fcs_new;
    merge_t       merged;

    assign out_free          = !out_vld_q || output_axis_tready;
    assign in_rdy            = out_free && (state_q == PASS) && rst_n;
    assign in_fire           = input_axis_tvalid && in_rdy;
    assign input_axis_tready = in_rdy;

    // Illegal strobes are flagged but the beat is still treated as 16 valid bytes.
    always_comb begin
        strb_cnt = strb_to_count(input_axis_tstrb);
        strb_ok  = input_axis_tlast ? (strb_cnt != 5'd0) : (input_axis_tstrb == 16'hFFFF);
        byte_cnt = strb_ok ? strb_cnt : 5'd16;
    end

    eth_crc_step u_crc_step (
        .crc_in  (crc_q),
        .data    (input_axis_tdata),
        .count   (byte_cnt),
        .crc_out (crc_fin)
    );

    assign fcs_new = ~crc_fin;
    assign merged  = fcs_merge(input_axis_tdata, byte_cnt, fcs_new);

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        fcs_hold_d = fcs_hold_q;
        hold_cnt_d = hold_cnt_q;
        out_dat_d  = out_dat_q;
        out_strb_d = out_strb_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        fcs_d      = fcs_q;
        fcs_vld_d  = 1'b0;
        bad_strb_d = 1'b0;

        if (out_free) out_vld_d = 1'b0;

        if (state_q == EXTRA) begin
            if (out_free) begin
                out_dat_d  = {96'h0, fcs_hold_q};
                out_strb_d = 16'((17'd1 << hold_cnt_q) - 17'd1);
                out_last_d = 1'b1;
                out_vld_d  = 1'b1;
                state_d    = PASS;
            end
        end else if (in_fire) begin
            bad_strb_d = !strb_ok;
            out_vld_d  = 1'b1;
            if (!input_axis_tlast) begin
                crc_d      = crc_fin;
                out_dat_d  = input_axis_tdata;
                out_strb_d = 16'hFFFF;
                out_last_d = 1'b0;
            end else begin
                crc_d     = CRC_INIT;
                fcs_d     = fcs_new;
                fcs_vld_d = 1'b1;
                out_dat_d = merged.dat;
                if (merged.ovf == 3'd0) begin
                    out_strb_d = 16'((17'd1 << (byte_cnt + 5'd4)) - 17'd1);
                    out_last_d = 1'b1;
                end else begin
                    // FCS bytes that spill past byte 15, shifted down to byte 0.
                    out_strb_d = 16'hFFFF;
                    out_last_d = 1'b0;
                    fcs_hold_d = fcs_new >> {5'd16 - byte_cnt, 3'b000};
                    hold_cnt_d = merged.ovf;
                    state_d    = EXTRA;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PASS;
            crc_q      <= CRC_INIT;
            fcs_hold_q <= '0;
            hold_cnt_q <= '0;
            out_dat_q  <= '0;
            out_strb_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            fcs_q      <= '0;
            fcs_vld_q  <= 1'b0;
            bad_strb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            fcs_hold_q <= fcs_hold_d;
            hold_cnt_q <= hold_cnt_d;
            out_dat_q  <= out_dat_d;
            out_strb_q <= out_strb_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            fcs_q      <= fcs_d;
            fcs_vld_q  <= fcs_vld_d;
            bad_strb_q <= bad_strb_d;
        end
    end

    assign output_axis_tdata  = out_dat_q;
    assign output_axis_tstrb  = out_strb_q;
    assign output_axis_tvalid = out_vld_q;
    assign output_axis_tlast  = out_last_q;
    assign output_fcs         = fcs_q;
    assign output_fcs_valid   = fcs_vld_q;
    assign bad_strb           = bad_strb_q;

endmodule

// File: tb/tb_axis_eth_fcs_insert.sv
// Directed and randomised-backpressure bench for axis_eth_fcs_insert.
module tb_axis_eth_fcs_insert;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_dat;
    logic [15:0]  in_strb;
    logic         in_vld;
    logic         in_rdy;
    logic         in_last;
    logic [127:0] out_dat;
    logic [15:0]  out_strb;
    logic         out_vld;
    logic         out_rdy;
    logic         out_last;
    logic [31:0]  fcs;
    logic         fcs_vld;
    logic         bad_strb;

    int checks = 0;
    int errors = 0;
    int bad_cnt = 0;
    int fcs_long = 0;
    int stall_viol = 0;
    bit rand_rdy = 1'b0;

    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [31:0] fcs_got_q[$];
    logic [31:0] fcs_exp_q[$];
    logic [7:0]  frm[$];

    axis_eth_fcs_insert dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_dat),
        .input_axis_tstrb   (in_strb),
        .input_axis_tvalid  (in_vld),
        .input_axis_tready  (in_rdy),
        .input_axis_tlast   (in_last),
        .output_axis_tdata  (out_dat),
        .output_axis_tstrb  (out_strb),
        .output_axis_tvalid (out_vld),
        .output_axis_tready (out_rdy),
        .output_axis_tlast  (out_last),
        .output_fcs         (fcs),
        .output_fcs_valid   (fcs_vld),
        .bad_strb           (bad_strb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output monitor: captures accepted beats, FCS pulses and stall stability.
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    bit    prev_fcs_vld = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        cur = {out_dat, out_strb, out_last};
        if (!rst_n) begin
            prev_stall   = 1'b0;
            prev_fcs_vld = 1'b0;
        end else begin
            if (prev_stall && (!out_vld || cur !== prev_beat)) stall_viol++;
            if (out_vld && out_rdy) got_q.push_back(cur);
            prev_stall = out_vld && !out_rdy;
            prev_beat  = cur;
            if (fcs_vld) fcs_got_q.push_back(fcs);
            if (fcs_vld && prev_fcs_vld) fcs_long++;
            prev_fcs_vld = fcs_vld;
            if (bad_strb) bad_cnt++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        fcs_got_q.delete();
        fcs_exp_q.delete();
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] s, input logic l);
        int n = 0;
        in_dat  = d;
        in_strb = s;
        in_last = l;
        in_vld  = 1'b1;
        @(negedge clk);
        while (!in_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic send_frame();
        logic [127:0] d;
        logic [15:0]  s;
        int L = frm.size();
        for (int base = 0; base < L; base += 16) begin
            d = '0;
            s = '0;
            for (int k = 0; k < 16 && base + k < L; k++) begin
                d[8*k +: 8] = frm[base+k];
                s[k] = 1'b1;
            end
            send_beat(d, s, (base + 16 >= L));
        end
    endtask

    // Reference: bit-serial CRC over the frame, FCS appended, re-chunked into 16-byte beats.
    task automatic model_frame();
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0]  b[$];
        beat_t       bt;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fcs_exp_q.push_back(c);
        b = frm;
        for (int j = 0; j < 4; j++) b.push_back(c[8*j +: 8]);
        for (int base = 0; base < b.size(); base += 16) begin
            bt = '0;
            for (int k = 0; k < 16 && base + k < b.size(); k++) begin
                bt.d[8*k +: 8] = b[base+k];
                bt.s[k] = 1'b1;
            end
            bt.l = (base + 16 >= b.size());
            exp_q.push_back(bt);
        end
    endtask

    task automatic wait_out(input int limit);
        int n = 0;
        while ((got_q.size() < exp_q.size() || fcs_got_q.size() < fcs_exp_q.size()) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        sync();
    endtask

    task automatic test_reset();
        in_vld = 1'b0; in_dat = '0; in_strb = '0; in_last = 1'b0; out_rdy = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_vld, out_last, fcs_vld, bad_strb} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {out_vld, out_last, fcs_vld, bad_strb});
        end
        checks++;
        if (out_dat !== 128'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", out_dat); end
        checks++;
        if (out_strb !== 16'h0) begin errors++; $display("FAIL reset_tstrb got %h exp 0", out_strb); end
        checks++;
        if (fcs !== 32'h0) begin errors++; $display("FAIL reset_fcs got %h exp 0", fcs); end
        checks++;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", in_rdy); end
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b exp 1", in_rdy); end
        sync();
    endtask

    task automatic test_check_value();
        beat_t want;
        clear_q();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        model_frame();
        send_frame();
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1) begin errors++; $display("FAIL cv_latency tvalid got %b exp 1", out_vld); end
        checks++;
        if (fcs_vld !== 1'b1 || fcs !== 32'hCBF43926) begin
            errors++; $display("FAIL cv_fcs got %b/%h exp 1/cbf43926", fcs_vld, fcs);
        end
        @(negedge clk);
        checks++;
        if (fcs_vld !== 1'b0) begin errors++; $display("FAIL cv_fcs_pulse got %b exp 0", fcs_vld); end
        wait_out(100);
        want = {128'h000000CB_F4392639_38373635_34333231, 16'h1FFF, 1'b1};
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL cv_beats got %0d exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== want) begin
                errors++; $display("FAIL cv_beat got %h/%h/%b exp %h/%h/%b",
                                   got_q[0].d, got_q[0].s, got_q[0].l, want.d, want.s, want.l);
            end
        end
    endtask

    task automatic test_64byte();
        clear_q();
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'((i * 13 + 5) & 255));
        model_frame();
        send_frame();
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL f64_extra_tready got %b exp 0", in_rdy); end
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL f64_tready_back got %b exp 1", in_rdy); end
        wait_out(200);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL f64_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL f64_beat%0d got %h/%h/%b exp %h/%h/%b", i,
                                   got_q[i].d, got_q[i].s, got_q[i].l, exp_q[i].d, exp_q[i].s, exp_q[i].l);
            end
        end
        checks++;
        if (got_q.size() == 5 && (got_q[4].s !== 16'h000F || got_q[4].l !== 1'b1)) begin
            errors++; $display("FAIL f64_extra got %h/%b exp 000f/1", got_q[4].s, got_q[4].l);
        end
        checks++;
        if (fcs_got_q.size() !== 1 || fcs_got_q[0] !== fcs_exp_q[0]) begin
            errors++; $display("FAIL f64_fcs got n=%0d exp %h", fcs_got_q.size(), fcs_exp_q[0]);
        end
    endtask

    task automatic test_n13();
        logic [31:0] f;
        clear_q();
        frm.delete();
        for (int i = 0; i < 61; i++) frm.push_back(8'((i * 29 + 11) & 255));
        model_frame();
        f = fcs_exp_q[0];
        send_frame();
        wait_out(200);
        checks++;
        if (got_q.size() !== 5) begin
            errors++; $display("FAIL n13_beats got %0d exp 5", got_q.size());
        end else begin
            checks++;
            if (got_q[3].s !== 16'hFFFF || got_q[3].l !== 1'b0 || got_q[3].d[127:104] !== f[23:0]
                || got_q[3].d[103:0] !== exp_q[3].d[103:0]) begin
                errors++; $display("FAIL n13_last_in got %h/%h/%b exp fcs %h", got_q[3].d, got_q[3].s, got_q[3].l, f);
            end
            checks++;
            if (got_q[4] !== {120'h0, f[31:24], 16'h0001, 1'b1}) begin
                errors++; $display("FAIL n13_extra got %h/%h/%b exp byte %h/0001/1", got_q[4].d, got_q[4].s, got_q[4].l, f[31:24]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL n13_beat%0d got %h exp %h", i, got_q[i].d, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic test_bad_strb();
        logic [127:0] d;
        int b0;
        clear_q();
        b0 = bad_cnt;
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'((i * 7 + 100) & 255));
        model_frame();
        for (int bt = 0; bt < 4; bt++) begin
            for (int k = 0; k < 16; k++) d[8*k +: 8] = frm[bt*16+k];
            send_beat(d, (bt == 0) ? 16'h00FF : (bt == 3) ? 16'h0F0F : 16'hFFFF, (bt == 3));
        end
        wait_out(200);
        checks++;
        if (bad_cnt - b0 !== 2) begin errors++; $display("FAIL bad_pulses got %0d exp 2", bad_cnt - b0); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bad_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bad_beat%0d got %h/%h/%b exp %h/%h/%b", i,
                                   got_q[i].d, got_q[i].s, got_q[i].l, exp_q[i].d, exp_q[i].s, exp_q[i].l);
            end
        end
        checks++;
        if (fcs_got_q.size() !== 1 || fcs_got_q[0] !== fcs_exp_q[0]) begin
            errors++; $display("FAIL bad_fcs got n=%0d exp %h", fcs_got_q.size(), fcs_exp_q[0]);
        end
    endtask

    task automatic test_random();
        int len;
        int nerr = 0;
        clear_q();
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            frm.delete();
            len = $urandom_range(60, 200);
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
            model_frame();
            send_frame();
        end
        wait_out(20000);
        rand_rdy = 1'b0;
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rnd_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                if (nerr++ < 10)
                    $display("FAIL rnd_beat%0d got %h/%h/%b exp %h/%h/%b", i,
                             got_q[i].d, got_q[i].s, got_q[i].l, exp_q[i].d, exp_q[i].s, exp_q[i].l);
            end
        end
        checks++;
        if (fcs_got_q.size() !== fcs_exp_q.size()) begin
            errors++; $display("FAIL rnd_fcs_count got %0d exp %0d", fcs_got_q.size(), fcs_exp_q.size());
        end
        for (int i = 0; i < fcs_exp_q.size() && i < fcs_got_q.size(); i++) begin
            checks++;
            if (fcs_got_q[i] !== fcs_exp_q[i]) begin
                errors++; $display("FAIL rnd_fcs%0d got %h exp %h", i, fcs_got_q[i], fcs_exp_q[i]);
            end
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stall_viol); end
        checks++;
        if (fcs_long !== 0) begin errors++; $display("FAIL fcs_pulse_width got %0d long exp 0", fcs_long); end
    endtask

    task automatic test_reset_extra();
        clear_q();
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'(i));
        send_frame();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_vld, out_last, fcs_vld, bad_strb, in_rdy} !== 5'b0) begin
            errors++; $display("FAIL rst_extra_flags got %b exp 00000", {out_vld, out_last, fcs_vld, bad_strb, in_rdy});
        end
        checks++;
        if (out_dat !== 128'h0 || out_strb !== 16'h0 || fcs !== 32'h0) begin
            errors++; $display("FAIL rst_extra_regs got %h/%h/%h exp 0/0/0", out_dat, out_strb, fcs);
        end
        sync();
        rst_n = 1'b1;
        sync();
        clear_q();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        model_frame();
        send_frame();
        wait_out(100);
        checks++;
        if (fcs_got_q.size() !== 1 || fcs_got_q[0] !== 32'hCBF43926) begin
            errors++; $display("FAIL rst_extra_fcs got n=%0d exp cbf43926", fcs_got_q.size());
        end
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL rst_extra_beat got n=%0d exp 1 matching beat", got_q.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_check_value();
        test_64byte();
        test_n13();
        test_bad_strb();
        test_random();
        test_reset_extra();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_eth_fcs_insert.md
# axis_eth_fcs_insert

Frame-level controller that sequences a 128-bit AXI4-Stream Ethernet frame through the CRC32 datapath and appends the 4-byte FCS to the frame tail. It sits between the packet generator and the MAC/TX output. It owns the CRC state, the FCS placement and the extra-beat state machine needed when the FCS does not fit in the last beat. Output is fully registered and honours downstream backpressure.

## Interface
- No parameters. Data width is fixed at 128 bits / 16 bytes.
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- input_axis_tdata  in  128  frame bytes; byte 0 is [7:0] and is first on the wire
- input_axis_tstrb  in  16  byte enables
- input_axis_tvalid  in  1  input beat valid
- input_axis_tready  out  1  input beat accepted when tvalid and tready are both high
- input_axis_tlast  in  1  last beat of frame
- output_axis_tdata  out  128  frame with FCS appended
- output_axis_tstrb  out  16  byte enables, contiguous from bit 0
- output_axis_tvalid  out  1  output beat valid
- output_axis_tready  in  1  downstream ready
- output_axis_tlast  out  1  last beat, including the FCS
- output_fcs  out  32  FCS of the last completed frame
- output_fcs_valid  out  1  one-cycle pulse when output_fcs updates
- bad_strb  out  1  one-cycle pulse on an illegal tstrb (see Operation)

## Operation
- CRC: reflected CRC32, polynomial 0x04C11DB7, initial value 0xFFFFFFFF. FCS = ~crc.
- Byte count per beat: n = number of contiguous ones in tstrb starting at bit 0.
- Non-last beats must have tstrb = 0xFFFF.
- Last beats must have a contiguous non-zero tstrb.
- On any other tstrb value, pulse bad_strb and treat the beat as full (n = 16). The data is still forwarded.
- No padding is inserted. Upstream guarantees frames of at least 60 bytes.
- States:
  - PASS: accept beats. On a non-last beat, crc_state <= crc_step(crc_state, data, 16) and the beat is forwarded unchanged.
  - Last beat, n ≤ 12: FCS goes into bytes n..n+3, LSB first. tstrb = (1<<(n+4))-1, tlast=1. crc_state <= 0xFFFFFFFF. Stay in PASS.
  - Last beat, n > 12: the first 16-n FCS bytes go into bytes n..15. tstrb=0xFFFF, tlast=0. The remaining n-12 FCS bytes are stored in fcs_hold. Go to EXTRA.
  - EXTRA: emit one beat with fcs_hold in bytes 0..(n-13), tstrb = (1<<(n-12))-1, tlast=1. Other tdata bytes are 0. Return to PASS when the beat is accepted.
- When a frame's final FCS is computed, output_fcs <= FCS and output_fcs_valid pulses for one cycle. This fires on acceptance of the input last beat, not on the EXTRA beat.
- Reset mid-frame: on deassertion the block starts clean in PASS with crc_state = 0xFFFFFFFF. The partial frame is lost.

## Timing
- One output register stage. An accepted input beat appears on the output the next cycle.
- input_axis_tready = (!output_axis_tvalid || output_axis_tready) && state==PASS && !rst.
- tready does not depend combinationally on input tvalid.
- Output holds data, tstrb and tlast stable while tvalid=1 and tready=0.
- Back-to-back frames have no gap when n ≤ 12. When n > 12, input_axis_tready is low for exactly the one cycle the EXTRA beat is loaded. With output_axis_tready held at 1, a new frame's first beat is accepted 2 cycles after the previous last beat.
- Reset values:
  - output_axis_tvalid/tlast = 0
  - output_axis_tdata = 0, output_axis_tstrb = 0
  - output_fcs = 0, output_fcs_valid = 0, bad_strb = 0
  - state = PASS, crc_state = 0xFFFFFFFF, fcs_hold = 0
- Simultaneous output accept and new input accept in the same cycle: the output register reloads with no bubble.

## Structure
- Package eth_fcs_pkg holds:
  - CRC32 polynomial and init constants.
  - The state enum {PASS, EXTRA}.
  - A strb_to_count function (returns 0 for an illegal tstrb).
  - An fcs_merge function (places FCS bytes at offset n and returns the overflow count).
- One sub-module: eth_crc_step. It is combinational, takes crc_state, 128-bit data and a byte count of 1..16, and returns crc_next. It is built as a byte-count mux over the per-width CRC iterations.

## Test plan
- Single beat "123456789" (bytes 0x31..0x39), tstrb=0x01FF, tlast. Expect:
  - Output bytes 9..12 = 26 39 F4 CB, tstrb=0x1FFF, tlast=1.
  - output_fcs=0xCBF43926 with a one-cycle valid pulse.
- 64-byte frame (4 full beats, last tstrb=0xFFFF). Expect a 5th beat with tstrb=0x000F, tlast=1, and the FCS matching the software model. tready is low for 1 cycle.
- Last beat tstrb=0x1FFF (n=13). Expect:
  - That beat has FCS bytes 0..2 at bytes 13..15, tstrb=0xFFFF, tlast=0.
  - The next beat has FCS byte 3 at byte 0, tstrb=0x0001, tlast=1.
- Random output_axis_tready toggling over 100 random frames. Expect the output stream to equal the model byte-for-byte, with no beat dropped or duplicated and beats held stable while stalled.
- Non-last beat with tstrb=0x00FF. Expect a bad_strb pulse, the beat forwarded, and the CRC computed over 16 bytes.
- Assert rst_n low mid-frame during EXTRA. Expect all outputs to take their reset values immediately. The next frame "123456789" yields 0xCBF43926.
